// File: rtl/regfile_scoreboard.sv
// Parametrised register file: two async read ports, one sync write port, per-register busy scoreboard
// and a sequential soft-clear engine. Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned IDX_W = ADDR_W + 1;
    localparam logic [IDX_W-1:0] NUM_REGS_I = IDX_W'(NUM_REGS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               clear_busy_q, clear_busy_d;
    logic               clear_done_q, clear_done_d;
    logic [DATA_W-1:0]  regs_q [DEPTH];
    logic [DATA_W-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0]   busy_q, busy_d;

    logic wr_ok, claim_ok, clearing;

    // Address is implemented and not the hard-wired zero register
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NUM_REGS_I) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok    = wr_en    && (state_q == IDLE) && addr_ok(wr_addr);
    assign claim_ok = claim_en && (state_q == IDLE) && addr_ok(claim_addr);
    assign clearing = (state_q == CLEAR);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        clear_busy_d = clear_busy_q;
        clear_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d      = CLEAR;
                    idx_d        = '0;
                    clear_busy_d = 1'b1;
                end
            end
            CLEAR: begin
                if (idx_q == LAST_IDX) begin
                    state_d      = DONE;
                    clear_busy_d = 1'b0;
                    clear_done_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d      = IDLE;
                clear_busy_d = 1'b0;
            end
        endcase
    end

    // Storage update: clear has priority; a claim overrides the busy-clear of a same-address write
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            regs_d[i] = regs_q[i];
            busy_d[i] = busy_q[i];
            if (clearing && (idx_q == IDX_W'(i))) begin
                regs_d[i] = '0;
                busy_d[i] = 1'b0;
            end else begin
                if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                    regs_d[i] = wr_data;
                    busy_d[i] = 1'b0;
                end
                if (claim_ok && (claim_addr == ADDR_W'(i))) begin
                    busy_d[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_data1 = addr_ok(rd_addr1) ? regs_q[rd_addr1] : '0;
        rd_busy1 = addr_ok(rd_addr1) && busy_q[rd_addr1];
        rd_data2 = addr_ok(rd_addr2) ? regs_q[rd_addr2] : '0;
        rd_busy2 = addr_ok(rd_addr2) && busy_q[rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
            rd_busy1 = claim_ok && (claim_addr == wr_addr);
        end
        if (wr_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
            rd_busy2 = claim_ok && (claim_addr == wr_addr);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b0;
            busy_q       <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            clear_busy_q <= clear_busy_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
            regs_q       <= regs_d;
        end
    end

    assign clear_busy = clear_busy_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: a 32-register and a 16-register instance share stimulus;
// expectations are queued by the stimulus and compared by a negedge monitor.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, claim_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, claim_en, clear_req;

    logic [DW-1:0] rd_data1, rd_data2, rd_data1_s, rd_data2_s;
    logic          rd_busy1, rd_busy2, rd_busy1_s, rd_busy2_s;
    logic          clear_busy, clear_done, clear_busy_s, clear_done_s;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
    );

    regfile_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(16), .ZERO_REG(1)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1_s), .rd_busy1(rd_busy1_s),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2_s), .rd_busy2(rd_busy2_s),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .clear_req(clear_req), .clear_busy(clear_busy_s), .clear_done(clear_done_s)
    );

    typedef enum int {S_D1, S_B1, S_D2, S_B2, S_CB, S_CD,
                      S_D1_S, S_B1_S, S_D2_S, S_B2_S, S_CB_S, S_CD_S} sig_t;
    typedef struct {
        string       name;
        sig_t        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] observe(input sig_t s);
        case (s)
            S_D1:    return rd_data1;
            S_B1:    return {31'b0, rd_busy1};
            S_D2:    return rd_data2;
            S_B2:    return {31'b0, rd_busy2};
            S_CB:    return {31'b0, clear_busy};
            S_CD:    return {31'b0, clear_done};
            S_D1_S:  return rd_data1_s;
            S_B1_S:  return {31'b0, rd_busy1_s};
            S_D2_S:  return rd_data2_s;
            S_B2_S:  return {31'b0, rd_busy2_s};
            S_CB_S:  return {31'b0, clear_busy_s};
            default: return {31'b0, clear_done_s};
        endcase
    endfunction

    task automatic expect_val(input string name, input sig_t s, input logic [31:0] v);
        exp_t e;
        e.name = name;
        e.sig  = s;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            exp_t        e;
            logic [31:0] got;
            e   = sb_q.pop_front();
            got = observe(e.sig);
            n_cmp++;
            if (got !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, got, e.exp, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = 1'b0;
        claim_en  = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic do_write(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
    endtask

    task automatic do_claim(input int a);
        claim_en   = 1'b1;
        claim_addr = AW'(a);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; claim_addr = '0; wr_data = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        rd_addr1 = 5'd5;
        expect_val("reset_d1", S_D1, 32'h0);
        expect_val("reset_b1", S_B1, 32'h0);
        expect_val("reset_clear_busy", S_CB, 32'h0);
        expect_val("reset_clear_done", S_CD, 32'h0);
        expect_val("reset_clear_busy_16", S_CB_S, 32'h0);
        tick();

        do_write(5, 32'hDEADBEEF);
        rd_addr1 = 5'd1; rd_addr2 = 5'd2;
        tick();

        idle();
        rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        expect_val("r5_port1", S_D1, 32'hDEADBEEF);
        expect_val("r5_port2", S_D2, 32'hDEADBEEF);
        expect_val("r5_busy1", S_B1, 32'h0);
        expect_val("r5_busy2", S_B2, 32'h0);
        do_write(0, 32'h1234);
        tick();

        idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd7;
        expect_val("r0_data", S_D1, 32'h0);
        expect_val("r0_busy", S_B1, 32'h0);
        expect_val("r7_busy_before_claim_edge", S_B2, 32'h0);
        do_claim(7);
        tick();

        idle();
        rd_addr1 = 5'd7;
        expect_val("r7_busy_after_claim", S_B1, 32'h1);
        expect_val("r7_data_after_claim", S_D1, 32'h0);
        tick();

        do_write(7, 32'hAA);
        rd_addr1 = 5'd3; rd_addr2 = 5'd4;
        tick();

        // Same-cycle claim+write to r7 while port 1 watches r7
        idle();
        rd_addr1 = 5'd7;
        expect_val("r7_data_cw_cycle", S_D1, BYP ? 32'hBB : 32'hAA);
        expect_val("r7_busy_cw_cycle", S_B1, BYP ? 32'h1 : 32'h0);
        do_write(7, 32'hBB);
        do_claim(7);
        tick();

        // Re-claim busy r7 while writing r8
        idle();
        rd_addr1 = 5'd7; rd_addr2 = 5'd8;
        expect_val("r7_data_after_cw", S_D1, 32'hBB);
        expect_val("r7_busy_after_cw", S_B1, 32'h1);
        expect_val("r8_bypass_data", S_D2, BYP ? 32'h88 : 32'h0);
        expect_val("r8_bypass_busy", S_B2, 32'h0);
        do_claim(7);
        do_write(8, 32'h88);
        tick();

        idle();
        expect_val("r7_busy_double_claim", S_B1, 32'h1);
        expect_val("r8_data", S_D2, 32'h88);
        expect_val("r8_busy", S_B2, 32'h0);
        tick();

        do_write(7, 32'h77);
        rd_addr1 = 5'd8; rd_addr2 = 5'd8;
        tick();

        idle();
        rd_addr1 = 5'd7; rd_addr2 = 5'd9;
        expect_val("r7_data_single_write", S_D1, 32'h77);
        expect_val("r7_busy_single_write", S_B1, 32'h0);
        expect_val("r9_bypass_data", S_D2, BYP ? 32'h55 : 32'h0);
        expect_val("r9_bypass_busy", S_B2, 32'h0);
        do_write(9, 32'h55);
        tick();

        idle();
        rd_addr1 = 5'd9; rd_addr2 = 5'd9;
        expect_val("r9_data", S_D2, 32'h55);
        do_write(20, 32'h2020);
        do_claim(0);
        tick();

        idle();
        rd_addr1 = 5'd20; rd_addr2 = 5'd0;
        expect_val("r20_data", S_D1, 32'h2020);
        expect_val("r20_data_16", S_D1_S, 32'h0);
        expect_val("r20_busy_16", S_B1_S, 32'h0);
        expect_val("r0_busy_after_claim", S_B2, 32'h0);
        expect_val("r0_data_after_claim", S_D2, 32'h0);
        do_claim(21);
        tick();

        idle();
        rd_addr1 = 5'd0; rd_addr2 = 5'd21;
        expect_val("r21_busy", S_B2, 32'h1);
        expect_val("r21_busy_16", S_B2_S, 32'h0);
        tick();

        for (int i = 1; i < 32; i++) begin
            do_write(i, 32'(i));
            rd_addr1 = '0; rd_addr2 = '0;
            tick();
        end
        idle();
        do_claim(3);
        tick();

        // Start soft clear; clear_req held as a level for a few cycles
        idle();
        rd_addr1 = 5'd3; rd_addr2 = 5'd17;
        expect_val("r3_busy_pre_clear", S_B1, 32'h1);
        expect_val("r3_data_pre_clear", S_D1, 32'h3);
        expect_val("r17_data_pre_clear", S_D2, 32'h11);
        expect_val("r17_data_16", S_D2_S, 32'h0);
        expect_val("clear_busy_pre", S_CB, 32'h0);
        clear_req = 1'b1;
        tick();

        for (int k = 0; k < 32; k++) begin
            idle();
            clear_req = (k < 3);
            if (k == 10) do_write(3, 32'h999);
            if (k == 11) do_claim(2);
            rd_addr1 = 5'd31;
            rd_addr2 = AW'(k);
            expect_val($sformatf("clear_busy_k%0d", k), S_CB, 32'h1);
            expect_val($sformatf("clear_done_k%0d", k), S_CD, 32'h0);
            expect_val($sformatf("r31_during_clear_k%0d", k), S_D1, 32'h1F);
            expect_val($sformatf("rk_during_clear_k%0d", k), S_D2, 32'(k));
            expect_val($sformatf("clear_busy16_k%0d", k), S_CB_S, (k < 16) ? 32'h1 : 32'h0);
            expect_val($sformatf("clear_done16_k%0d", k), S_CD_S, (k == 16) ? 32'h1 : 32'h0);
            expect_val($sformatf("rk16_during_clear_k%0d", k), S_D2_S, (k < 16) ? 32'(k) : 32'h0);
            tick();
        end

        idle();
        expect_val("clear_done_pulse", S_CD, 32'h1);
        expect_val("clear_busy_in_done", S_CB, 32'h0);
        tick();
        expect_val("clear_done_after", S_CD, 32'h0);
        expect_val("clear_busy_after", S_CB, 32'h0);
        tick();

        for (int i = 0; i < 32; i++) begin
            rd_addr1 = AW'(i);
            rd_addr2 = AW'(i);
            expect_val($sformatf("post_clear_d_r%0d", i), S_D1, 32'h0);
            expect_val($sformatf("post_clear_b_r%0d", i), S_B1, 32'h0);
            expect_val($sformatf("post_clear16_d_r%0d", i), S_D2_S, 32'h0);
            expect_val($sformatf("post_clear16_b_r%0d", i), S_B2_S, 32'h0);
            tick();
        end

        // Reset in the middle of a clear
        do_write(31, 32'h31);
        tick();
        idle();
        do_write(4, 32'h44);
        do_claim(29);
        tick();
        idle();
        clear_req = 1'b1;
        tick();
        idle();
        for (int k = 0; k < 10; k++) tick();
        rd_addr1 = 5'd31; rd_addr2 = 5'd29;
        expect_val("r31_before_midclear_reset", S_D1, 32'h31);
        expect_val("r29_busy_before_midclear_reset", S_B2, 32'h1);
        expect_val("clear_busy_before_reset", S_CB, 32'h1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_val("midclear_reset_clear_busy", S_CB, 32'h0);
        expect_val("midclear_reset_clear_done", S_CD, 32'h0);
        expect_val("midclear_reset_r31", S_D1, 32'h0);
        expect_val("midclear_reset_r29_busy", S_B2, 32'h0);
        do_write(12, 32'hC);
        tick();
        idle();
        rd_addr1 = 5'd12;
        expect_val("write_after_midclear_reset", S_D1, 32'hC);
        for (int k = 0; k < 40; k++) begin
            expect_val($sformatf("no_clear_done_k%0d", k), S_CD, 32'h0);
            expect_val($sformatf("no_clear_busy_k%0d", k), S_CB, 32'h0);
            tick();
        end

        tick();
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-cycle CPU's register file: configurable width and depth, two asynchronous read ports, one synchronous write port, hard-wired zero register.
- Adds a per-register busy scoreboard for multi-cycle writers (e.g. load/multiply) and a sequential soft-clear engine.
- Sits between decode (read/claim) and writeback (write) in the datapath.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, implemented registers; must be between 2 and 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0 and is never written, claimed or busy; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_data1  out  DATA_W  read port 1 data (combinational).
- rd_busy1  out  1  register at rd_addr1 has a pending write.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data2  out  DATA_W  read port 2 data (combinational).
- rd_busy2  out  1  register at rd_addr2 has a pending write.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- claim_en  in  1  mark claim_addr busy (pending writer issued).
- claim_addr  in  ADDR_W  register to claim.
- clear_req  in  1  start soft clear; single-cycle pulse or level.
- clear_busy  out  1  soft clear in progress.
- clear_done  out  1  one-cycle pulse when soft clear completes.

Behaviour:
- Reset (rst_n=0 at a rising edge): all registers 0, all busy bits 0, FSM to IDLE, clear_busy=0, clear_done=0. Reset wins over every other input, including mid-clear.
- Read: rd_dataN = reg[rd_addrN]; rd_busyN = busy[rd_addrN]. Zero latency.
- Read returns data 0 and busy 0 when rd_addrN >= NUM_REGS, or when rd_addrN = 0 with ZERO_REG=1.
- Write: on a rising edge with wr_en=1, a valid address and FSM=IDLE, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Write is ignored when wr_addr >= NUM_REGS, or when wr_addr = 0 with ZERO_REG=1.
- Claim: on a rising edge with claim_en=1, a valid address and FSM=IDLE, busy[claim_addr] <= 1. Invalid or zero-register addresses are ignored.
- Write and claim to the same address in the same cycle: data is written and busy ends at 1 (claim wins).
- Write and claim to different addresses: both take effect.
- Busy tracking is a flag, not a counter: a second claim to an already-busy register keeps it at 1, and one write clears it.
- FSM states: IDLE, CLEAR, DONE.
- IDLE -> CLEAR on clear_req=1. Clear index idx <= 0; clear_busy <= 1.
- CLEAR: each cycle reg[idx] <= 0 and busy[idx] <= 0, then idx++. When idx = NUM_REGS-1, go to DONE.
- The clear takes exactly NUM_REGS cycles. wr_en, claim_en and clear_req are ignored throughout.
- DONE: clear_done=1 and clear_busy=0 for this one cycle, then IDLE. Inputs are still ignored in DONE.
- Reads stay live during CLEAR. Registers not yet cleared return their old values.
- idx is ADDR_W+1 bits, so it never wraps before the terminal compare.
- clear_busy is registered: 1 from the cycle after the clear_req edge through the last CLEAR cycle.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: a read port forwards same-cycle writeback. If wr_en=1, FSM=IDLE, wr_addr is valid and wr_addr = rd_addrN, then rd_dataN = wr_data (combinational). In that case rd_busyN = 0, unless claim_en=1 with claim_addr = wr_addr in the same cycle, which gives rd_busyN = 1.
- Not defined: reads return stored state only; a write becomes visible in the cycle after its edge.

Test Plan:
- Reset, then write 0xDEADBEEF to r5; read r5 on both ports -> 0xDEADBEEF, busy 0. Write 0x1234 to r0 -> r0 reads 0.
- Claim r7 -> next cycle rd_busy1=1 for r7. Write 0xAA to r7 -> busy 0, data 0xAA. Same-cycle claim+write to r7 -> busy 1, data written.
- Bypass: wr_en to r9 with 0x55, rd_addr1=9 in the same cycle -> rd_data1=0x55 with REGFILE_BYPASS_EN defined, old value (0) without it.
- Fill r1-r31 with index values, pulse clear_req -> clear_busy=1 for 32 cycles; a write during clear is ignored; clear_done pulses once; every register reads 0 and not busy.
- Assert rst_n=0 at cycle 10 of a clear -> next cycle FSM IDLE, clear_busy=0, no clear_done, all registers 0.
- Parameters NUM_REGS=16, ADDR_W=5: write to r20 is ignored, r20 reads 0; soft clear lasts 16 cycles.
